// File: rtl/apb_rr_scheduler_if.sv
// Bundle of requester-side command/completion signals and the APB bus for apb_rr_scheduler.
// The master modport is the scheduler's view; slave is the view of the requesters and APB slaves around it.
interface apb_rr_scheduler_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_wr;
  logic [2*NREQ-1:0] req_slv;
  logic [4*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        rdata;
  logic              err;
  logic              busy;
  logic              psel1;
  logic              psel2;
  logic              penable;
  logic              pwrite;
  logic [3:0]        paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req, req_wr, req_slv, req_addr, req_wdata, prdata, pready, pslverr,
    output gnt, done, rdata, err, busy, psel1, psel2, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req, req_wr, req_slv, req_addr, req_wdata, prdata, pready, pslverr,
    input  gnt, done, rdata, err, busy, psel1, psel2, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_scheduler.sv
// Round-robin arbiter that runs one APB transfer (SETUP, ACCESS) per granted requester command.
// Define APB_TIMEOUT_EN to terminate an ACCESS phase after TIMEOUT cycles without pready.
module apb_rr_scheduler #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  apb_rr_scheduler_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DERR   = 2'd3;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("apb_rr_scheduler: NREQ or TIMEOUT out of range");
  end

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] cur_oh;
  logic            cur_wr;

  logic            found;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            win_wr;
  logic [1:0]      win_slv;
  logic [3:0]      win_addr;
  logic [7:0]      win_wdata;
  logic            timed_out;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NREQ) sum = sum - NREQ;
    return PW'(sum);
  endfunction

  // First requester at or after ptr, wrapping; fields of the winner are muxed out by index.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found     = 1'b0;
    win       = '0;
    win_oh    = '0;
    win_wr    = 1'b0;
    win_slv   = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[wrap_add(ptr, k)]) begin
        found = 1'b1;
        win   = wrap_add(ptr, k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (win == PW'(k)) begin
        win_oh[k] = found;
        win_wr    = bus.req_wr[k];
        win_slv   = bus.req_slv[2*k +: 2];
        win_addr  = bus.req_addr[4*k +: 4];
        win_wdata = bus.req_wdata[8*k +: 8];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  logic [7:0] tcnt;

  // The count reaches TIMEOUT at the edge closing the TIMEOUT-th ACCESS cycle without pready.
  assign timed_out = !bus.pready && (tcnt == TLIM);

  always_ff @(posedge pclk) begin
    if (preset || state != ST_ACCESS) tcnt <= '0;
    else if (!bus.pready)             tcnt <= tcnt + 8'd1;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    if (preset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      cur_oh        <= '0;
      cur_wr        <= 1'b0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.rdata     <= '0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.psel1     <= 1'b0;
      bus.psel2     <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
    end else begin
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.rdata <= '0;
      bus.err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            bus.gnt  <= win_oh;
            bus.busy <= 1'b1;
            cur_oh   <= win_oh;
            cur_wr   <= win_wr;
            ptr      <= wrap_add(win, 1);
            if (win_slv == 2'b01 || win_slv == 2'b10) begin
              bus.psel1  <= (win_slv == 2'b01);
              bus.psel2  <= (win_slv == 2'b10);
              bus.paddr  <= win_addr;
              bus.pwrite <= win_wr;
              bus.pwdata <= win_wr ? win_wdata : 8'h00;
              state      <= ST_SETUP;
            end else begin
              state <= ST_DERR;
            end
          end
        end
        ST_SETUP: begin
          bus.penable <= 1'b1;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A timeout only fires with pready low, so pready always wins a tie.
          if (bus.pready || timed_out) begin
            bus.psel1   <= 1'b0;
            bus.psel2   <= 1'b0;
            bus.penable <= 1'b0;
            bus.done    <= cur_oh;
            bus.err     <= bus.pready ? bus.pslverr : 1'b1;
            bus.rdata   <= (bus.pready && !cur_wr) ? bus.prdata : 8'h00;
            bus.busy    <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_DERR: begin
          bus.done <= cur_oh;
          bus.err  <= 1'b1;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Scoreboard bench for apb_rr_scheduler: a transaction-level model predicts each grant and completion,
// a monitor compares them as the DUT presents gnt/done, and a slave model answers the APB bus.
module tb_apb_rr_scheduler;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int DROP = 0;  // requester lowers req after its grant
  localparam int KEEP = 1;  // requester keeps the same command pending
  localparam int RENEW = 2; // requester issues a fresh random command

  typedef struct {
    logic       v;
    logic       wr;
    logic [1:0] slv;
    logic [3:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct {
    int         idx;
    logic [1:0] slv;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] pwdata;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  apb_rr_scheduler_if #(.NREQ(NREQ)) bus ();

  apb_rr_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t exp_q[$];
  exp_t cur;
  bit   active = 1'b0;
  int   gnt_cyc = 0;

  cmd_t       pend[NREQ];
  int         mptr = 0;
  int         s_wait = 0;
  logic [7:0] s_prdata = 8'h00;
  logic       s_slverr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [1:0] slv, input logic [3:0] a, input logic [7:0] d);
    cmd_t c;
    c.v = 1'b1; c.wr = wr; c.slv = slv; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    int r;
    logic [1:0] s;
    r = int'($urandom_range(0, 7));
    s = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b01 : 2'b10;
    return mk(1'($urandom), s, 4'($urandom), 8'($urandom));
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]             = pend[i].v;
      bus.req_wr[i]          = pend[i].wr;
      bus.req_slv[2*i +: 2]  = pend[i].slv;
      bus.req_addr[4*i +: 4] = pend[i].addr;
      bus.req_wdata[8*i +: 8] = pend[i].wdata;
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NREQ; i++) pend[i] = '{v: 1'b0, wr: 1'b0, slv: 2'b00, addr: 4'h0, wdata: 8'h00};
    drive_req();
  endtask

  // Called at a falling edge; resets DUT and model together.
  task automatic recover();
    clear_pend();
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    mptr = 0;
  endtask

  // Predict the winner and its completion, present the requests, wait for the grant.
  task automatic issue(input int wait_n, input logic [7:0] prd, input logic slverr, input int after,
                       output bit ok);
    exp_t e;
    int   w;
    int   n;
    bit   to;
    ok = 1'b0;
    w  = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && pend[(mptr + k) % NREQ].v) w = (mptr + k) % NREQ;
    end
    if (w < 0) return;
    e.idx    = w;
    e.slv    = pend[w].slv;
    e.wr     = pend[w].wr;
    e.addr   = pend[w].addr;
    e.pwdata = pend[w].wr ? pend[w].wdata : 8'h00;
    if (e.slv == 2'b01 || e.slv == 2'b10) begin
      to      = TO_EN && (wait_n >= TIMEOUT);
      e.lat   = 2 + (to ? TIMEOUT - 1 : wait_n);
      e.err   = to ? 1'b1 : slverr;
      e.rdata = (to || e.wr) ? 8'h00 : prd;
    end else begin
      e.lat   = 1;
      e.err   = 1'b1;
      e.rdata = 8'h00;
    end
    exp_q.push_back(e);
    mptr     = (w + 1) % NREQ;
    s_wait   = wait_n;
    s_prdata = prd;
    s_slverr = slverr;
    drive_req();
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (bus.gnt == '0 && n < 8);
    check("gnt_wait", 64'(bus.gnt != '0), 64'(1));
    if (bus.gnt == '0) begin
      recover();
      return;
    end
    if (after == DROP)       pend[w].v = 1'b0;
    else if (after == RENEW) pend[w]   = rand_cmd();
    drive_req();
    ok = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (bus.done == '0 && n < budget);
    check("done_wait", 64'(bus.done != '0), 64'(1));
    if (bus.done == '0) recover();
  endtask

  task automatic round(input int wait_n, input logic [7:0] prd, input logic slverr, input int after);
    bit ok;
    issue(wait_n, prd, slverr, after, ok);
    if (ok) wait_done(wait_n + 8);
  endtask

  // APB slave: raises pready after s_wait ACCESS cycles, noise elsewhere.
  int acnt = 0;
  initial begin
    bus.pready  = 1'b0;
    bus.prdata  = 8'h00;
    bus.pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (bus.penable && (bus.psel1 || bus.psel2)) begin
        if (acnt >= s_wait) begin
          bus.pready  = 1'b1;
          bus.prdata  = s_prdata;
          bus.pslverr = s_slverr;
        end else begin
          bus.pready  = 1'b0;
          bus.prdata  = 8'($urandom);
          bus.pslverr = 1'($urandom);
        end
        acnt++;
      end else begin
        acnt        = 0;
        bus.pready  = 1'($urandom);
        bus.prdata  = 8'($urandom);
        bus.pslverr = 1'($urandom);
      end
    end
  end

  // Monitor: pops the expectation on gnt, closes it on done, and watches the bus every cycle.
  initial begin
    forever begin
      @(posedge pclk);
      #2;
      cyc++;
      if (preset) begin
        check("reset_outputs", 64'({bus.gnt, bus.done, bus.rdata, bus.err, bus.busy, bus.psel1, bus.psel2,
                                    bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 64'(0));
        exp_q.delete();
        active = 1'b0;
      end else begin
        if (bus.gnt != '0) begin
          if (exp_q.size() == 0 || active) begin
            check("gnt_unexpected", 64'(bus.gnt), 64'(0));
          end else begin
            cur     = exp_q.pop_front();
            active  = 1'b1;
            gnt_cyc = cyc;
            check("gnt_onehot", 64'(bus.gnt), 64'(1) << cur.idx);
          end
        end
        if (bus.done != '0) begin
          if (!active) begin
            check("done_unexpected", 64'(bus.done), 64'(0));
          end else begin
            check("done_onehot", 64'(bus.done), 64'(1) << cur.idx);
            check("done_rdata", 64'(bus.rdata), 64'(cur.rdata));
            check("done_err", 64'(bus.err), 64'(cur.err));
            check("done_latency", 64'(cyc - gnt_cyc), 64'(cur.lat));
            active = 1'b0;
          end
        end else begin
          check("idle_rdata_err", 64'({bus.rdata, bus.err}), 64'(0));
        end
        if (active) begin
          check("psel", 64'({bus.psel1, bus.psel2}), 64'({cur.slv == 2'b01, cur.slv == 2'b10}));
          if (cur.slv == 2'b01 || cur.slv == 2'b10) begin
            check("penable", 64'(bus.penable), 64'(cyc != gnt_cyc));
            check("apb_cmd", 64'({bus.paddr, bus.pwrite, bus.pwdata}), 64'({cur.addr, cur.wr, cur.pwdata}));
          end else begin
            check("penable_derr", 64'(bus.penable), 64'(0));
          end
        end else begin
          check("bus_idle", 64'({bus.psel1, bus.psel2, bus.penable}), 64'(0));
        end
        check("busy", 64'(bus.busy), 64'(active));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_pend();
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;

    // Write to slave 1: gnt cycle 1, ACCESS cycle 2, done cycle 3.
    pend[0] = mk(1'b1, 2'b01, 4'h5, 8'hA7);
    round(0, 8'h00, 1'b0, DROP);

    // Two requesters held high on slave 2: grants alternate.
    pend[0] = mk(1'b0, 2'b10, 4'h1, 8'h11);
    pend[1] = mk(1'b0, 2'b10, 4'h2, 8'h22);
    repeat (4) round(0, 8'($urandom), 1'b0, KEEP);
    clear_pend();

    // Read with three wait states.
    pend[2] = mk(1'b0, 2'b10, 4'hC, 8'h55);
    round(3, 8'h3C, 1'b0, DROP);

    // Decode errors and a slave error on a read.
    pend[0] = mk(1'b1, 2'b11, 4'h7, 8'hEE);
    round(0, 8'h00, 1'b0, DROP);
    pend[1] = mk(1'b0, 2'b00, 4'h3, 8'h00);
    round(0, 8'h00, 1'b0, DROP);
    pend[1] = mk(1'b0, 2'b01, 4'h9, 8'h00);
    round(0, 8'h77, 1'b1, DROP);

    // Randomized traffic with contention, re-requests and field changes after grant.
    for (int r = 0; r < 80; r++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i].v && $urandom_range(0, 1) == 1) pend[i] = rand_cmd();
        any |= pend[i].v;
      end
      if (!any) pend[$urandom_range(0, NREQ - 1)] = rand_cmd();
      round(TO_EN ? int'($urandom_range(0, TIMEOUT + 2)) : int'($urandom_range(0, 5)),
            8'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end
    clear_pend();

`ifdef APB_TIMEOUT_EN
    // Slave never answers: transfer ends after TIMEOUT ACCESS cycles with err.
    pend[0] = mk(1'b0, 2'b01, 4'hA, 8'h00);
    round(1000, 8'h5A, 1'b0, DROP);
`endif

    // Reset in the middle of ACCESS from requester 1, so ptr is nonzero beforehand.
    clear_pend();
    pend[1] = mk(1'b0, 2'b01, 4'h6, 8'h00);
    begin
      bit ok;
      issue(1000, 8'h00, 1'b0, DROP, ok);
      if (ok) begin
        n = 0;
        while (!bus.penable && n < 4) begin
          @(negedge pclk);
          n++;
        end
        check("penable_wait", 64'(bus.penable), 64'(1));
`ifndef APB_TIMEOUT_EN
        repeat (50) @(negedge pclk);
        check("still_in_access", 64'({bus.penable, bus.busy, bus.psel1}), 64'(3'b111));
`endif
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        mptr = 0;
        repeat (4) @(negedge pclk);
      end
    end

    // After reset the pointer is back at 0, so requester 0 wins against all others.
    for (int i = 0; i < NREQ; i++) pend[i] = mk(1'b0, 2'b01, 4'(i + 8), 8'h00);
    round(0, 8'hC3, 1'b0, DROP);
    clear_pend();

    repeat (3) @(negedge pclk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_rr_scheduler.md
Name: apb_rr_scheduler

Overview:
- Shares one APB bus (two slaves, psel1/psel2) between NREQ local requesters.
- Round-robin arbitration; the winner's command drives one full APB transfer (SETUP then ACCESS).
- Returns a one-hot completion pulse with read data and error status.
- Sits between the requesting engines and the APB slaves; the arbiter owns psel/penable/paddr/pwrite/pwdata.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- TIMEOUT, 16, ACCESS-phase wait limit in cycles; used only with APB_TIMEOUT_EN; legal range 2..255.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request level.
- req_wr  in  NREQ  per-requester direction: 1 write, 0 read.
- req_slv  in  2*NREQ  per-requester slave select; field i = bits [2i+1:2i]; 01 selects slave 1, 10 selects slave 2.
- req_addr  in  4*NREQ  per-requester address; field i = bits [4i+3:4i].
- req_wdata  in  8*NREQ  per-requester write data; field i = bits [8i+7:8i].
- gnt  out  NREQ  one-hot, one-cycle pulse: command i accepted.
- done  out  NREQ  one-hot, one-cycle pulse: transfer i finished.
- rdata  out  8  read data; valid while done is high.
- err  out  1  error status; valid while done is high.
- busy  out  1  high in any state other than IDLE.
- psel1, psel2, penable, pwrite  out  1  APB control signals.
- paddr  out  4  APB address.
- pwdata  out  8  APB write data.
- prdata  in  8  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Internal state after reset: state = IDLE, ptr = 0, timeout counter = 0.
- A reset asserted mid-transfer aborts the transfer at the next edge. No done pulse is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS, DERR.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching from ptr upward, wrapping modulo NREQ.
  - At that edge: gnt[winner] <= 1; latch the winner's wr, slv, addr and wdata; ptr <= (winner+1) mod NREQ.
  - If the latched slv is 01 or 10: drive paddr, pwrite and pwdata (pwdata = wdata on writes, 0x00 on reads), set the matching psel, and go to SETUP.
  - If the latched slv is 00 or 11: assert no psel and go to DERR.
- SETUP: exactly one cycle with psel=1, penable=0. At the next edge penable <= 1 and the state goes to ACCESS.
- ACCESS:
  - Holds psel, penable, paddr, pwrite and pwdata stable while pready=0.
  - At the edge where pready=1: psel1/psel2/penable <= 0; done[i] <= 1; err <= pslverr; rdata <= prdata on reads, 0x00 on writes; state goes to IDLE.
- DERR: one cycle, no bus activity. At the next edge: done[i] <= 1, err <= 1, rdata <= 0x00, state goes to IDLE.
- Latency (grant edge = cycle 0):
  - gnt high in cycle 1, SETUP in cycle 1, ACCESS from cycle 2.
  - With pready=1 in cycle 2, done is high in cycle 3.
  - Each pready=0 cycle adds one cycle.
  - DERR: done is high in cycle 2.
- Arbitration happens only in IDLE. The earliest next grant is at the edge that ends the done cycle, so there is no back-to-back SETUP.
- req is level-sensitive and is consumed on gnt. A requester holding req high after its gnt issues a new request.
- req, slv, addr and wdata need only be valid while req is high in IDLE. Changes to them after gnt have no effect.
- gnt, done, rdata and err return to 0 in the cycle after their pulse.
- psel1 and psel2 are never high together. penable is high only while in ACCESS.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering ACCESS and increments on each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT with pready still 0: terminate the transfer (psel/penable <= 0), done[i] <= 1, err <= 1, rdata <= 0x00, state goes to IDLE.
  - If pready=1 in the same cycle the limit is hit, pready wins and the transfer completes normally.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits for pready indefinitely; the TIMEOUT parameter is unused.

Test Plan:
- Write: NREQ=2, req0=1, slv=01, addr=0x5, wdata=0xA7, pready=1 → gnt=01 in cycle 1; psel1=1, paddr=5, pwrite=1, pwdata=A7; penable=1 in cycle 2; done=01, err=0 in cycle 3.
- Fairness: req0 and req1 held high continuously, both slv=10 → grants alternate 01, 10, 01, 10; psel2 only; ptr wraps correctly.
- Read with wait states: slv=10, pready=0 for 3 ACCESS cycles then 1, prdata=0x3C → done in cycle 6, rdata=0x3C, err=0; address and control stable throughout ACCESS.
- Decode error and slave error: slv=11 → no psel, done in cycle 2 with err=1, rdata=0x00. Separately, slv=01 with pslverr=1 on the pready cycle → err=1.
- Timeout: APB_TIMEOUT_EN defined, TIMEOUT=4, pready held 0 → transfer terminated after 4 ACCESS cycles, done with err=1. Without the macro → still in ACCESS after 50 cycles.
- Reset mid-ACCESS: preset=1 for one cycle while penable=1 → next cycle all outputs 0, no done pulse, ptr=0; a following request is served normally.
